// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Bundle of decode/writeback signals for register_file_mp.
//               master = decode/writeback side, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);

  // Decode-side read ports (packed, port r at [r*W +: W])
  logic [NUM_READ*ADDR_WIDTH-1:0]  read_index;
  logic [NUM_READ*DATA_WIDTH-1:0]  read_data;
  logic [NUM_READ-1:0]             read_busy;

  // Writeback-side write ports (packed the same way)
  logic [NUM_WRITE-1:0]            write_enable;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_reg;
  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data;

  // Pending scoreboard set from decode at issue
  logic                            pend_set;
  logic [ADDR_WIDTH-1:0]           pend_reg;
  logic                            any_busy;

  // Mirror of the designated v0 register
  logic [DATA_WIDTH-1:0]           register_v0;

  modport master (
    output read_index,
    output write_enable,
    output write_reg,
    output write_data,
    output pend_set,
    output pend_reg,
    input  read_data,
    input  read_busy,
    input  any_busy,
    input  register_v0
  );

  modport slave (
    input  read_index,
    input  write_enable,
    input  write_reg,
    input  write_data,
    input  pend_set,
    input  pend_reg,
    output read_data,
    output read_busy,
    output any_busy,
    output register_v0
  );

endinterface : register_file_mp_if
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Parametrised multi-port register file with a per-register
//               pending (busy) scoreboard. Register 0 is hardwired to zero.
//               Optional macro REGFILE_BYPASS_EN enables same-cycle
//               write-to-read forwarding on every read port.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int V0_INDEX   = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  register_file_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_V0_IDX  = ADDR_WIDTH'(V0_INDEX);
  localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = '0;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      w_pend_next;

  // --------------------------------------------------------------------------
  // Unpacked view of the write ports. A write to index 0 is treated as if the
  // port were idle, so neither the array nor the scoreboard sees it.
  // --------------------------------------------------------------------------
  logic [NUM_WRITE-1:0]  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_idx [NUM_WRITE];
  logic [DATA_WIDTH-1:0] w_wr_dat [NUM_WRITE];

  generate
    for (genvar gw = 0; gw < NUM_WRITE; gw++) begin : g_wr_unpack
      assign w_wr_idx[gw] = bus.write_reg[gw*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wr_dat[gw] = bus.write_data[gw*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_en[gw]  = bus.write_enable[gw] && (w_wr_idx[gw] != c_ZERO_IDX);
    end
  endgenerate

  // Pend-set qualified the same way: index 0 can never become busy.
  logic w_pset_en;
  assign w_pset_en = bus.pend_set && (bus.pend_reg != c_ZERO_IDX);

  // --------------------------------------------------------------------------
  // Register array update. Ports are visited in ascending order so the last
  // non-blocking assignment, i.e. the highest-numbered port, wins a collision.
  // --------------------------------------------------------------------------
  // Array write: async clear, then per-port writes with highest port priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (w_wr_en[w]) begin
          r_regs[w_wr_idx[w]] <= w_wr_dat[w];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending scoreboard. Clears from writeback are applied first and the set
  // from decode last, so a set to the same index overrides the clear: the
  // newly issued producer is younger than the one retiring now.
  // --------------------------------------------------------------------------
  // Next pending vector: clear on write, then set on issue
  always_comb begin
    w_pend_next = r_pend;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (w_wr_en[w]) begin
        w_pend_next[w_wr_idx[w]] = 1'b0;
      end
    end
    if (w_pset_en) begin
      w_pend_next[bus.pend_reg] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  // Pending register: async clear, otherwise load next vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  assign bus.any_busy    = |r_pend;
  assign bus.register_v0 = r_regs[c_V0_IDX];

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  generate
    for (genvar gr = 0; gr < NUM_READ; gr++) begin : g_read
      logic [ADDR_WIDTH-1:0] w_idx;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_busy;

      assign w_idx = bus.read_index[gr*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_BYPASS_EN
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] w_fwd;
      logic                  w_pset_hit;

      // Forwarding match: last matching port in ascending order wins.
      // Suppressed during reset so reads stay zero while it is asserted.
      always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (w_wr_en[w] && (w_wr_idx[w] == w_idx) && !reset) begin
            w_hit = 1'b1;
            w_fwd = w_wr_dat[w];
          end
        end
      end

      assign w_pset_hit = w_pset_en && (bus.pend_reg == w_idx) && !reset;

      // Read mux: zero register, forwarded write, or stored state
      always_comb begin
        w_data = r_regs[w_idx];
        w_busy = r_pend[w_idx];
        if (w_idx == c_ZERO_IDX) begin
          w_data = '0;
          w_busy = 1'b0;
        end else if (w_hit) begin
          // The retiring write resolves the hazard unless decode re-marks it.
          w_data = w_fwd;
          w_busy = w_pset_hit;
        end
      end
`else
      // Read mux: zero register or pre-edge stored state
      always_comb begin
        w_data = r_regs[w_idx];
        w_busy = r_pend[w_idx];
        if (w_idx == c_ZERO_IDX) begin
          w_data = '0;
          w_busy = 1'b0;
        end
      end
`endif

      assign bus.read_data[gr*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign bus.read_busy[gr]                          = w_busy;
    end
  endgenerate

endmodule : register_file_mp
`default_nettype wire
